// File: rtl/candy_avb_pio_pkg.sv
// Shared definitions for the PIO LED blinker: register map, CTRL bit positions, blink states.
package candy_avb_pio_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_ON     = 2'd1;
  localparam logic [1:0] ADDR_OFF    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_INV  = 1;
  localparam int unsigned CTRL_MODE = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StOff  = 2'd2
  } blink_state_e;

endpackage

// File: rtl/candy_avb_phase_timer.sv
// Loadable down-counter timing one ON or OFF phase; o_zero marks the last cycle of a phase.
module candy_avb_phase_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_value,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/candy_avb_pio_led_blinker.sv
// LED driver behind the PIO out_port: follows the PIO bit or blinks while it is high.
module candy_avb_pio_led_blinker
  import candy_avb_pio_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEF_ON  = 25000000,
  parameter int unsigned DEF_OFF = 25000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_address,
  input  logic        i_chipselect,
  input  logic        i_write_n,
  input  logic [31:0] i_writedata,
  output logic [31:0] o_readdata,
  input  logic        i_pio_in,
  output logic        o_led_out
);

  logic [2:0]       r_ctrl;
  logic [CNT_W-1:0] r_on_time;
  logic [CNT_W-1:0] r_off_time;
  logic [15:0]      r_blink_cnt;
  logic             r_led;
  blink_state_e     r_state;
  blink_state_e     w_state_d;

  logic             w_wr;
  logic [2:0]       w_ctrl_d;
  logic             w_run;
  logic             w_raw;
  logic             w_load;
  logic             w_dec;
  logic             w_inc;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_on_load;
  logic [CNT_W-1:0] w_off_load;
  logic [CNT_W-1:0] w_cnt_value;
  logic             w_cnt_zero;

  assign w_wr     = i_chipselect & ~i_write_n;
  assign w_ctrl_d = (w_wr && (i_address == ADDR_CTRL)) ? i_writedata[2:0] : r_ctrl;

  // Blinking continues only if enabled+blink both now and after any CTRL write this cycle.
  assign w_run = r_ctrl[CTRL_EN] & r_ctrl[CTRL_MODE] & w_ctrl_d[CTRL_EN] & w_ctrl_d[CTRL_MODE];

  // A programmed time of 0 still yields a one-cycle phase.
  assign w_on_load  = (r_on_time == '0) ? '0 : r_on_time - CNT_W'(1);
  assign w_off_load = (r_off_time == '0) ? '0 : r_off_time - CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ctrl     <= '0;
      r_on_time  <= CNT_W'(DEF_ON);
      r_off_time <= CNT_W'(DEF_OFF);
    end else if (w_wr) begin
      unique case (i_address)
        ADDR_CTRL: r_ctrl     <= i_writedata[2:0];
        ADDR_ON:   r_on_time  <= CNT_W'(i_writedata);
        ADDR_OFF:  r_off_time <= CNT_W'(i_writedata);
        default:   ;
      endcase
    end
  end

  // Clearing through STATUS wins over a simultaneous increment.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_blink_cnt <= '0;
    end else if (w_wr && (i_address == ADDR_STATUS)) begin
      r_blink_cnt <= '0;
    end else if (w_inc && (r_blink_cnt != 16'hFFFF)) begin
      r_blink_cnt <= r_blink_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_led   <= r_ctrl[CTRL_EN] ? (w_raw ^ r_ctrl[CTRL_INV]) : 1'b0;
    end
  end

  assign w_raw = r_ctrl[CTRL_MODE] ? (r_state == StOn) : i_pio_in;

  always_comb begin
    w_state_d  = r_state;
    w_load     = 1'b0;
    w_load_val = w_on_load;
    w_dec      = 1'b0;
    w_inc      = 1'b0;
    if (!w_run) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_pio_in) begin
            w_state_d = StOn;
            w_load    = 1'b1;
            w_inc     = 1'b1;
          end
        end
        StOn: begin
          if (!i_pio_in) begin
            w_state_d = StIdle;
          end else if (w_cnt_zero) begin
            w_state_d  = StOff;
            w_load     = 1'b1;
            w_load_val = w_off_load;
          end else begin
            w_dec = 1'b1;
          end
        end
        StOff: begin
          if (!i_pio_in) begin
            w_state_d = StIdle;
          end else if (w_cnt_zero) begin
            w_state_d = StOn;
            w_load    = 1'b1;
            w_inc     = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  candy_avb_phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_value    (w_cnt_value),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    o_readdata = '0;
    unique case (i_address)
      ADDR_CTRL:   o_readdata = {29'd0, r_ctrl};
      ADDR_ON:     o_readdata = 32'(r_on_time);
      ADDR_OFF:    o_readdata = 32'(r_off_time);
      ADDR_STATUS: o_readdata = {r_blink_cnt, 13'd0, (r_state == StOn), i_pio_in, r_led};
      default:     o_readdata = '0;
    endcase
  end

  assign o_led_out = r_led;

  logic w_unused;
  assign w_unused = ^w_cnt_value;

endmodule

// File: tb/tb_candy_avb_pio_led_blinker.sv
// Self-checking bench: register vector table, directed blink corner cases, randomized model run.
module tb_candy_avb_pio_led_blinker;

  localparam int unsigned DEF_ON  = 25000000;
  localparam int unsigned DEF_OFF = 25000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        pio_in = 1'b0;
  logic        led_out;

  int n_tests = 0;
  int n_fail  = 0;

  candy_avb_pio_led_blinker #(
    .CNT_W   (32),
    .DEF_ON  (DEF_ON),
    .DEF_OFF (DEF_OFF)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_address    (address),
    .i_chipselect (chipselect),
    .i_write_n    (write_n),
    .i_writedata  (writedata),
    .o_readdata   (readdata),
    .i_pio_in     (pio_in),
    .o_led_out    (led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pio_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        found;
    logic [3:0]  ctrl_v;
    int          on_v, off_v, on_e, off_e, p;
    bit          m_run, on_now, raw, m_led;
    int          m_t, m_cnt;
    logic        exp_seq2[10];

    vecs[0]  = '{1'b0, 2'd0, 32'h0,        2'd0, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,        2'd1, DEF_ON};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,        2'd2, DEF_OFF};
    vecs[3]  = '{1'b0, 2'd0, 32'h0,        2'd3, 32'h0};
    vecs[4]  = '{1'b1, 2'd0, 32'hFFFFFFF8, 2'd0, 32'h0};
    vecs[5]  = '{1'b1, 2'd0, 32'h00000006, 2'd0, 32'h6};
    vecs[6]  = '{1'b1, 2'd1, 32'hDEADBEEF, 2'd1, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 2'd2, 32'h00000001, 2'd2, 32'h1};
    vecs[8]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 2'd1, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 2'd0, 32'h0,        2'd0, 32'h6};
    vecs[10] = '{1'b1, 2'd0, 32'h00000000, 2'd3, 32'h0};

    tick();
    do_reset();
    check("reset_led", {31'd0, led_out}, 32'h0);
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].raddr, d);
      check($sformatf("vec%0d", i), d, vecs[i].exp);
    end

    // Follow mode, then inverted follow
    do_reset();
    wr(2'd0, 32'h1);
    pio_in = 1'b1;
    check("t1_lag_before", {31'd0, led_out}, 32'h0);
    tick();
    check("t1_follow_hi", {31'd0, led_out}, 32'h1);
    pio_in = 1'b0;
    check("t1_hold_hi", {31'd0, led_out}, 32'h1);
    tick();
    check("t1_follow_lo", {31'd0, led_out}, 32'h0);
    wr(2'd0, 32'h3);
    tick();
    check("t1_inv_lo_in", {31'd0, led_out}, 32'h1);
    pio_in = 1'b1;
    tick();
    check("t1_inv_hi_in", {31'd0, led_out}, 32'h0);

    // Blink ON=3 OFF=2
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd2);
    pio_in = 1'b1;
    wr(2'd0, 32'h5);
    exp_seq2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t2_led%0d", i), {31'd0, led_out}, {31'd0, exp_seq2[i]});
    end
    rd(2'd3, d);
    check("t2_cnt_a", {16'd0, d[31:16]}, 32'd2);
    for (int i = 0; i < 5; i++) tick();
    rd(2'd3, d);
    check("t2_cnt_b", {16'd0, d[31:16]}, 32'd3);

    // Drop pio_in in the first ON cycle (two more cycles were left)
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd2);
    pio_in = 1'b1;
    wr(2'd0, 32'h5);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rd(2'd3, d);
      if (d[2]) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("t3_reach_on", {31'd0, found}, 32'h1);
    pio_in = 1'b0;
    tick();
    rd(2'd3, d);
    check("t3_state_idle", {31'd0, d[2]}, 32'h0);
    check("t3_led_still", {31'd0, led_out}, 32'h1);
    tick();
    check("t3_led_off", {31'd0, led_out}, 32'h0);

    // Zero times: toggle every cycle
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd0);
    pio_in = 1'b1;
    wr(2'd0, 32'h5);
    tick();
    check("t4_first", {31'd0, led_out}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t4_tog%0d", i), {31'd0, led_out}, {31'd0, ~i[0]});
    end

    // ON_TIME rewritten mid-phase applies to the next ON phase only
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd2);
    pio_in = 1'b1;
    wr(2'd0, 32'h5);
    tick();
    wr(2'd1, 32'd10);
    check("t5_led2", {31'd0, led_out}, 32'h1);
    for (int k = 3; k <= 17; k++) begin
      tick();
      check($sformatf("t5_led%0d", k), {31'd0, led_out},
            {31'd0, (k <= 4) || (k >= 7 && k <= 16)});
    end

    // STATUS clear colliding with OFF->ON increment, then reset mid-phase
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd1);
    pio_in = 1'b1;
    wr(2'd0, 32'h5);
    tick();
    tick();
    rd(2'd3, d);
    check("t6_pre_cnt", {16'd0, d[31:16]}, 32'd1);
    check("t6_pre_off", {31'd0, d[2]}, 32'h0);
    wr(2'd3, 32'h0);
    rd(2'd3, d);
    check("t6_clear_wins", {16'd0, d[31:16]}, 32'd0);
    check("t6_now_on", {31'd0, d[2]}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_led", {31'd0, led_out}, 32'h0);
    rd(2'd0, d);
    check("t6_rst_ctrl", d, 32'h0);
    rd(2'd1, d);
    check("t6_rst_on", d, DEF_ON);
    rd(2'd2, d);
    check("t6_rst_off", d, DEF_OFF);
    rd(2'd3, d);
    check("t6_rst_status", d, 32'h2);

    // Randomized segments against a phase-arithmetic model
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      on_v   = $urandom_range(0, 4);
      off_v  = $urandom_range(0, 4);
      ctrl_v = 4'($urandom_range(0, 7));
      wr(2'd1, 32'(on_v));
      wr(2'd2, 32'(off_v));
      wr(2'd0, {29'd0, ctrl_v[2:0]});
      address = 2'd3;
      on_e  = (on_v == 0) ? 1 : on_v;
      off_e = (off_v == 0) ? 1 : off_v;
      p     = on_e + off_e;
      m_run = 0;
      m_t   = 0;
      m_cnt = 0;
      m_led = 0;
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 3) == 0) pio_in = ~pio_in;
        on_now = m_run && ((m_t % p) < on_e);
        raw    = ctrl_v[2] ? on_now : pio_in;
        @(posedge clk);
        m_led = ctrl_v[0] ? (raw ^ ctrl_v[1]) : 1'b0;
        if (!(ctrl_v[0] && ctrl_v[2])) begin
          m_run = 0;
        end else if (!m_run) begin
          if (pio_in) begin
            m_run = 1;
            m_t   = 0;
            m_cnt++;
          end
        end else if (!pio_in) begin
          m_run = 0;
        end else begin
          m_t++;
          if ((m_t % p) == 0) m_cnt++;
        end
        #1;
        on_now = m_run && ((m_t % p) < on_e);
        check($sformatf("rnd%0d_c%0d_led", seg, c), {31'd0, led_out}, {31'd0, m_led});
        check($sformatf("rnd%0d_c%0d_status", seg, c), readdata,
              {m_cnt[15:0], 13'd0, on_now, pio_in, m_led});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
